// File: rtl/coeff_pkg.sv
// coeff_pkg -- shared definitions for the coefficient loader.
//   CWIDTH      : default coefficient word width in bits
//   NTAP        : default number of filter taps
//   state_t     : loader FSM state encoding
//   coeff_arr_t : packed coefficient array at the default sizes (tap 0 in the low slice)
//   idx_width() : width of a tap index able to hold 0..n-1 (at least one bit)
package coeff_pkg;

    localparam int CWIDTH = 11;
    localparam int NTAP   = 37;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [NTAP-1:0][CWIDTH-1:0] coeff_arr_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coeff_bank.sv
// coeff_bank -- shadow/active register pair for the coefficient set.
// The loader writes words into the shadow bank one tap at a time. A commit copies
// the whole shadow bank into the active bank in a single clock. The filter only
// sees the active bank, so it never observes a partially written set.
// Ports:
//   clk     : clock, rising edge
//   srst    : synchronous active-high reset, clears both banks
//   wr_en   : write wr_data into shadow[wr_idx]
//   wr_idx  : shadow tap index
//   wr_data : coefficient word, stored bit-exact
//   commit  : copy shadow -> active
//   coeff   : active bank, tap k at coeff[k*CWIDTH +: CWIDTH]
module coeff_bank #(
    parameter int CWIDTH = coeff_pkg::CWIDTH,
    parameter int NTAP   = coeff_pkg::NTAP,
    parameter int IW     = coeff_pkg::idx_width(NTAP)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [CWIDTH-1:0]      wr_data,
    input  logic                   commit,
    output logic [NTAP*CWIDTH-1:0] coeff
);

    // One shadow/active register pair per tap. Each pair is declared inside its
    // own generate iteration, so every register has exactly one driver.
    generate
        for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
            logic [CWIDTH-1:0] shadow_reg;
            logic [CWIDTH-1:0] active_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (wr_en && (wr_idx == IW'(gi))) begin
                        shadow_reg <= wr_data;
                    end
                    if (commit) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign coeff[gi*CWIDTH +: CWIDTH] = active_reg;
        end
    endgenerate

endmodule

// File: rtl/coeff_loader.sv
// coeff_loader -- double-buffered coefficient loader for a FIR datapath.
// A host streams NTAP words (tap 0 first) after load_start. Once the last word
// is accepted, the complete set is committed to the active bank. The filter keeps
// running on the previous set until the new set is committed.
// Ports:
//   CLK, RST       : clock and synchronous active-high reset
//   load_start     : begin a new load; in LOAD it restarts the load and pulses err
//   load_abort     : abandon the load in progress; pulses err (wins over load_start)
//   cin_data/valid : coefficient word stream
//   cin_ready      : high in LOAD
//   en_req         : host request to run the filter
//   coeff          : active set, tap k at coeff[k*CWIDTH +: CWIDTH]
//   EN             : registered en_req AND "a set has been committed"
//   busy           : high in LOAD and COMMIT
//   done / err     : one-cycle pulses for a new active set / a discarded partial load
module coeff_loader #(
    parameter int CWIDTH = coeff_pkg::CWIDTH,
    parameter int NTAP   = coeff_pkg::NTAP
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   load_start,
    input  logic                   load_abort,
    input  logic [CWIDTH-1:0]      cin_data,
    input  logic                   cin_valid,
    output logic                   cin_ready,
    input  logic                   en_req,
    output logic [NTAP*CWIDTH-1:0] coeff,
    output logic                   EN,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    import coeff_pkg::*;

    localparam int              IW       = idx_width(NTAP);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NTAP - 1);

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            commit_reg, commit_next;
    logic            err_reg, err_next;
    logic            done_reg;
    logic            set_valid_reg;
    logic            en_reg;
    logic            wr_en;

    // Next-state logic. In LOAD, abort has priority over restart, and both have
    // priority over a word transfer. A word offered on an abort or restart cycle
    // is dropped, because that set is being discarded anyway.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        commit_next = 1'b0;
        err_next    = 1'b0;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    err_next   = 1'b1;
                end else if (load_start) begin
                    idx_next = '0;
                    err_next = 1'b1;
                end else if (cin_valid) begin
                    wr_en = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = COMMIT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            COMMIT: begin
                // Single-cycle state. The copy itself is issued from a register
                // one edge later, so the new set and done appear together two
                // edges after the last transfer.
                commit_next = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            commit_reg    <= 1'b0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
            set_valid_reg <= 1'b0;
            en_reg        <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            commit_reg <= commit_next;
            err_reg    <= err_next;
            done_reg   <= commit_reg;
            if (commit_reg) begin
                set_valid_reg <= 1'b1;
            end
            en_reg <= en_req & set_valid_reg;
        end
    end

    coeff_bank #(
        .CWIDTH (CWIDTH),
        .NTAP   (NTAP),
        .IW     (IW)
    ) u_bank (
        .clk     (CLK),
        .srst    (RST),
        .wr_en   (wr_en),
        .wr_idx  (idx_reg),
        .wr_data (cin_data),
        .commit  (commit_reg),
        .coeff   (coeff)
    );

    // Gating with RST holds the handshake and status outputs low for the whole
    // time reset is asserted, including the cycle before the first reset edge.
    assign cin_ready = (state_reg == LOAD) && !RST;
    assign busy      = ((state_reg == LOAD) || (state_reg == COMMIT)) && !RST;
    assign done      = done_reg;
    assign err       = err_reg;
    assign EN        = en_reg;

endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader -- directed self-checking bench for coeff_loader.
// A vector table covers single-cycle control behaviour. Hand-written sequences
// cover full loads, toggled valid, abort, restart, and reset during COMMIT.
module tb_coeff_loader;

    import coeff_pkg::*;

    localparam int CW = CWIDTH;
    localparam int NT = NTAP;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               load_start = 1'b0;
    logic               load_abort = 1'b0;
    logic [CW-1:0]      cin_data = '0;
    logic               cin_valid = 1'b0;
    logic               en_req = 1'b0;
    logic               cin_ready;
    logic [NT*CW-1:0]   coeff;
    logic               EN;
    logic               busy;
    logic               done;
    logic               err;

    coeff_loader #(.CWIDTH(CW), .NTAP(NT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load_start (load_start),
        .load_abort (load_abort),
        .cin_data   (cin_data),
        .cin_valid  (cin_valid),
        .cin_ready  (cin_ready),
        .en_req     (en_req),
        .coeff      (coeff),
        .EN         (EN),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = -1;
    logic en_at_done = 1'b0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (!RST) begin
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                en_at_done = EN;
            end
            if (err === 1'b1) err_cnt++;
        end
    end

    typedef struct {
        logic          start;
        logic          abort;
        logic          valid;
        logic [CW-1:0] data;
        logic          en;
        logic [4:0]    exp;   // {cin_ready, busy, done, err, EN}
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // mode 0: tap k must equal k+1; mode 1: every tap must equal val
    task automatic chk_coeff(input string name, input int mode, input logic [CW-1:0] val);
        int first_bad;
        logic [CW-1:0] got;
        logic [CW-1:0] want;
        logic [CW-1:0] got_bad;
        logic [CW-1:0] want_bad;
        first_bad = -1;
        got_bad = '0;
        want_bad = '0;
        for (int k = 0; k < NT; k++) begin
            got  = coeff[k*CW +: CW];
            want = (mode == 0) ? CW'(k + 1) : val;
            if (got !== want && first_bad < 0) begin
                first_bad = k;
                got_bad = got;
                want_bad = want;
            end
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: tap %0d got 0x%0h expected 0x%0h", name, first_bad, got_bad, want_bad);
        end else begin
            $display("ok   %s: all %0d taps", name, NT);
        end
    endtask

    // Called on a negedge; returns on the negedge after the edge of the last transfer.
    task automatic send_words(input int n, input int mode, input logic [CW-1:0] val, input bit toggle);
        int sent;
        int iter;
        bit ph;
        sent = 0;
        iter = 0;
        ph = 1'b1;
        while (sent < n && iter < 500) begin
            cin_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            if (cin_valid) cin_data = (mode == 0) ? CW'(sent + 1) : val;
            else           cin_data = CW'('h555);
            if (cin_valid && cin_ready === 1'b1) sent++;
            iter++;
            @(negedge CLK);
        end
        cin_valid = 1'b0;
        if (sent < n) begin
            total++;
            bad++;
            $display("FAIL send_words: only %0d of %0d words accepted", sent, n);
        end
    endtask

    task automatic start_load();
        @(negedge CLK);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int d0;
        int e0;

        //                start abort valid data     en    {rdy,busy,done,err,EN}
        vt[0] = '{1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 5'b00000};  // idle after reset
        vt[1] = '{1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 5'b11000};  // start -> LOAD
        vt[2] = '{1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 5'b00010};  // abort -> IDLE, err
        vt[3] = '{1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 5'b00000};  // abort in IDLE ignored
        vt[4] = '{1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 5'b11000};  // start -> LOAD
        vt[5] = '{1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 5'b11010};  // restart, err
        vt[6] = '{1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 5'b00010};  // abort beats start
        vt[7] = '{1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 5'b00000};  // en_req, no set -> EN 0
        vt[8] = '{1'b0, 1'b0, 1'b1, 11'h3FF, 1'b1, 5'b00000};  // valid in IDLE ignored

        // reset state
        repeat (3) @(negedge CLK);
        chk("reset cin_ready", 32'(cin_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset EN", 32'(EN), 32'd0);
        chk_coeff("reset coeff", 1, '0);
        RST = 1'b0;

        // vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            load_start = vt[i].start;
            load_abort = vt[i].abort;
            cin_valid  = vt[i].valid;
            cin_data   = vt[i].data;
            en_req     = vt[i].en;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d {rdy,busy,done,err,EN}", i),
                32'({cin_ready, busy, done, err, EN}), 32'(vt[i].exp));
        end
        @(negedge CLK);
        load_start = 1'b0;
        load_abort = 1'b0;
        cin_valid  = 1'b0;
        en_req     = 1'b1;

        // continuous load of 1..NT
        d0 = done_cnt;
        start_load();
        start_cyc = cyc;
        send_words(NT, 0, '0, 1'b0);
        repeat (4) @(negedge CLK);
        chk("A done count", 32'(done_cnt - d0), 32'd1);
        chk("A done latency", 32'(done_cyc - start_cyc), 32'd39);
        chk("A EN at done", 32'(en_at_done), 32'd0);
        chk("A EN after", 32'(EN), 32'd1);
        chk("A busy after", 32'(busy), 32'd0);
        chk_coeff("A coeff", 0, '0);

        // same load with valid toggling; EN must stay up during the load
        d0 = done_cnt;
        start_load();
        chk("B busy in load", 32'(busy), 32'd1);
        chk("B EN in load", 32'(EN), 32'd1);
        send_words(NT, 0, '0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("B done count", 32'(done_cnt - d0), 32'd1);
        chk_coeff("B coeff", 0, '0);

        // abort after 20 words of 0x7FF
        d0 = done_cnt;
        e0 = err_cnt;
        start_load();
        send_words(20, 1, 11'h7FF, 1'b0);
        load_abort = 1'b1;
        @(negedge CLK);
        load_abort = 1'b0;
        repeat (4) @(negedge CLK);
        chk("C err count", 32'(err_cnt - e0), 32'd1);
        chk("C done count", 32'(done_cnt - d0), 32'd0);
        chk("C busy", 32'(busy), 32'd0);
        chk_coeff("C coeff kept", 0, '0);

        // restart after 10 words, then a full set of 0x400
        d0 = done_cnt;
        e0 = err_cnt;
        start_load();
        send_words(10, 1, 11'h123, 1'b0);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        send_words(NT, 1, 11'h400, 1'b0);
        repeat (4) @(negedge CLK);
        chk("D err count", 32'(err_cnt - e0), 32'd1);
        chk("D done count", 32'(done_cnt - d0), 32'd1);
        chk_coeff("D coeff", 1, 11'h400);

        // reset while in COMMIT
        d0 = done_cnt;
        e0 = err_cnt;
        start_load();
        send_words(NT, 1, 11'h0AA, 1'b0);
        chk("E in COMMIT {rdy,busy}", 32'({cin_ready, busy}), 32'b01);
        RST = 1'b1;
        @(negedge CLK);
        chk("E reset {rdy,busy,done,err,EN}", 32'({cin_ready, busy, done, err, EN}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("E done count", 32'(done_cnt - d0), 32'd0);
        chk("E err count", 32'(err_cnt - e0), 32'd0);
        chk("E EN", 32'(EN), 32'd0);
        chk_coeff("E coeff cleared", 1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 Parameter CWIDTH, default 11: coefficient word width in bits.
REQ-002 Parameter NTAP, default 37: number of filter coefficients.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 load_start  input  1  one-cycle request to begin loading a new coefficient set.
REQ-006 load_abort  input  1  discard the partial set and return to idle.
REQ-007 cin_data  input  CWIDTH  coefficient word, two's complement; tap 0 first.
REQ-008 cin_valid  input  1  cin_data holds a valid word.
REQ-009 cin_ready  output  1  loader accepts a word this cycle.
REQ-010 en_req  input  1  host request to run the filter.
REQ-011 coeff  output  CWIDTH x NTAP  active coefficient array, consumed by the filter datapath.
REQ-012 EN  output  1  filter enable, driven to the filter datapath.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 done  output  1  one-cycle pulse when a new set becomes active.
REQ-015 err  output  1  one-cycle pulse on restart or abort of an unfinished load.

Function
REQ-016 The block SHALL hold two banks: shadow (write side) and active (drives coeff); the filter SHALL never see a partially loaded set.
REQ-017 The FSM SHALL have states IDLE, LOAD and COMMIT.
REQ-018 IDLE -> LOAD on load_start; the tap index SHALL be cleared to 0.
REQ-019 In LOAD, cin_ready SHALL be 1; a transfer occurs when cin_valid and cin_ready are both 1, writes shadow[index], and increments index.
REQ-020 The transfer at index NTAP-1 SHALL move the FSM to COMMIT; cin_ready SHALL be 0 in IDLE and COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle: active <= shadow, done <= 1, set_valid <= 1, FSM -> IDLE.
REQ-022 Latency: last transfer on edge t; new coeff values and done are visible after edge t+2; done is high for exactly one cycle.
REQ-023 load_start in LOAD SHALL restart the load (index <= 0, stays in LOAD) and pulse err; the shadow contents are not cleared.
REQ-024 load_abort in LOAD SHALL return to IDLE and pulse err; active is unchanged. In IDLE or COMMIT, load_abort is ignored.
REQ-025 Simultaneous load_abort and load_start SHALL give priority to load_abort.
REQ-026 load_start in COMMIT SHALL be ignored.
REQ-027 busy SHALL be 1 in LOAD and COMMIT, and 0 otherwise.
REQ-028 EN SHALL be registered as en_req AND set_valid; the filter keeps running on the old set during LOAD.
REQ-029 index SHALL be ceil(log2(NTAP)) bits wide and SHALL never exceed NTAP-1.
REQ-030 Words SHALL be stored bit-exact, with no sign extension or saturation.

Reset
REQ-031 While RST is 1 at an edge: FSM = IDLE, index = 0, both banks all zero, set_valid = 0.
REQ-032 Outputs during reset: EN = 0, done = 0, err = 0, busy = 0, cin_ready = 0.
REQ-033 RST during LOAD or COMMIT SHALL discard the load without a done or err pulse.

Structure
REQ-034 Package coeff_pkg SHALL hold NTAP, CWIDTH, the FSM state enum and the coefficient array typedef.
REQ-035 Sub-module coeff_bank SHALL implement the shadow/active register pair, with write-enable, write-index and commit inputs.
REQ-036 Target size: 120-400 lines of RTL.

Verification
REQ-037 Reset, then load words 1..37 continuously (cin_valid held at 1) -> coeff[k] = k+1; done is high once, 39 cycles after load_start; busy is low afterwards.
REQ-038 Same load with cin_valid toggling every other cycle -> identical final coeff; no word is lost or duplicated.
REQ-039 Active set = 1..37, then load 0x7FF for 20 words and abort -> err pulses; coeff stays 1..37; no done pulse.
REQ-040 Restart mid-load after 10 words, then send 37 words of 0x400 -> one err pulse; every coeff = 0x400; one done pulse.
REQ-041 en_req = 1 before any commit -> EN = 0; after the first done -> EN = 1 one cycle later and stays 1 through a subsequent LOAD.
REQ-042 Assert RST in COMMIT -> all coeff = 0, EN = 0, no done pulse.
